tdm_pwm_update_sched: RTL

Configuration scheduler in front of tdm_pwm_64bit. It accepts per-LED target writes from a host valid/ready port and holds them in a 16-entry shadow register file with a pending mask. It serialises the writes onto the PWM core's single update port (update_en/update_idx/target_in), using round-robin order and a minimum issue spacing. An optional synchronous mode holds all writes until a commit strobe, then drains them as one atomic batch.

---
 rtl/tdm_pwm_pkg.sv | 30 +++
 rtl/tdm_rr_pick.sv | 33 +++
 rtl/tdm_pwm_update_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tdm_pwm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pwm_pkg
// Shared constants and types for the TDM PWM update scheduler.
//   NUM_CH / IDX_W / TGT_W : channel count, index width and target width,
//                            fixed to match the PWM core's pwm_bus
//   tgt_t, ch_mask_t, ch_idx_t : target word, per-channel mask, channel index
//   sched_state_e          : scheduler FSM states
//   onehot()               : channel index to one-hot channel mask
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package tdm_pwm_pkg;

    localparam int NUM_CH = 16;
    localparam int IDX_W  = 4;
    localparam int TGT_W  = 64;

    typedef logic [TGT_W-1:0]  tgt_t;
    typedef logic [NUM_CH-1:0] ch_mask_t;
    typedef logic [IDX_W-1:0]  ch_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

    function automatic ch_mask_t onehot(input ch_idx_t idx);
        return ch_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/tdm_rr_pick.sv
// -----------------------------------------------------------------------------
// tdm_rr_pick
// Combinational rotating priority encoder: returns the first requesting
// channel at or above i_ptr, wrapping from the top channel back to 0.
//   i_req   : request mask, one bit per channel
//   i_ptr   : channel that has highest priority this cycle
//   o_found : at least one request is set
//   o_idx   : selected channel (i_ptr when nothing is requested)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tdm_rr_pick
    import tdm_pwm_pkg::*;
(
    input  ch_mask_t i_req,
    input  ch_idx_t  i_ptr,
    output logic     o_found,
    output ch_idx_t  o_idx
);

    // The index sum is IDX_W bits wide, so it wraps at NUM_CH for free.
    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!o_found && i_req[i_ptr + IDX_W'(i)]) begin
                o_found = 1'b1;
                o_idx   = i_ptr + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tdm_pwm_update_sched.sv
// -----------------------------------------------------------------------------
// tdm_pwm_update_sched
// Serialises host target writes onto the PWM core's single update port.
// Writes land in a shadow register file and set a pending bit; pending
// channels are issued round-robin with at least ISSUE_GAP cycles between
// update pulses. In sync mode writes are held until commit, then drained as
// one atomic batch while the write port is closed.
//   clk, rst_n              : clock, asynchronous active-low reset
//   en                      : 0 freezes issuing (writes still accepted)
//   wr_valid/wr_ready       : host write handshake; wr_idx/wr_target payload
//   sync_mode, commit       : hold-until-commit mode and its batch strobe
//   update_en/update_idx/target_in : registered update port to the PWM core
//   busy, pend_mask, coalesce_cnt  : status
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tdm_pwm_update_sched
    import tdm_pwm_pkg::*;
#(
    parameter int unsigned ISSUE_GAP = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TGT_W-1:0]  wr_target,
    input  logic              sync_mode,
    input  logic              commit,
    output logic              update_en,
    output logic [IDX_W-1:0]  update_idx,
    output logic [TGT_W-1:0]  target_in,
    output logic              busy,
    output logic [NUM_CH-1:0] pend_mask,
    output logic [15:0]       coalesce_cnt
);

    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;
    tgt_t             r_shadow [NUM_CH];
    ch_mask_t         r_pend;
    ch_mask_t         r_batch;
    ch_idx_t          r_rr_ptr;
    logic [GAP_W-1:0] r_gap;
    logic             r_update_en;
    ch_idx_t          r_update_idx;
    tgt_t             r_target;
    logic [15:0]      r_coal;

    ch_mask_t w_cand;
    ch_mask_t w_set;
    ch_mask_t w_clr;
    ch_idx_t  w_pick_idx;
    logic     w_pick_found;
    logic     w_issue;
    logic     w_wr_fire;
    logic     w_batch_load;
    logic     w_coal_inc;

    // The write port is closed for the whole drain so the batch stays atomic.
    assign wr_ready  = (r_state == IDLE);
    assign w_wr_fire = wr_valid && wr_ready;

    // Candidates: the latched batch while draining, the live pending set in
    // immediate mode, nothing while sync mode is collecting writes.
    always_comb begin
        w_cand = '0;
        if (r_state == DRAIN) begin
            w_cand = r_batch;
        end else if (!sync_mode) begin
            w_cand = r_pend;
        end
    end

    tdm_rr_pick u_pick (
        .i_req   (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_issue = en && (r_gap == '0) && w_pick_found;
    assign w_set   = w_wr_fire ? onehot(wr_idx) : '0;
    assign w_clr   = w_issue ? onehot(w_pick_idx) : '0;

    // A write that lands on the channel being issued this cycle is not an
    // overwrite of pending data: the issue takes the old value out.
    assign w_coal_inc = w_wr_fire && r_pend[wr_idx]
                        && !(w_issue && (w_pick_idx == wr_idx))
                        && (r_coal != 16'hFFFF);

    // FSM next state
    always_comb begin
        w_state_nxt  = r_state;
        w_batch_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (commit && sync_mode && (r_pend != '0)) begin
                    w_state_nxt  = DRAIN;
                    w_batch_load = 1'b1;
                end
            end
            DRAIN: begin
                if (r_batch == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= '0;
            r_batch      <= '0;
            r_rr_ptr     <= '0;
            r_gap        <= '0;
            r_update_en  <= 1'b0;
            r_update_idx <= '0;
            r_target     <= '0;
            r_coal       <= '0;
        end else begin
            // Set wins over clear so a colliding write re-arms the channel.
            r_pend <= (r_pend & ~w_clr) | w_set;

            if (w_batch_load) begin
                r_batch <= r_pend;
            end else begin
                r_batch <= r_batch & ~w_clr;
            end

            r_update_en <= w_issue;
            if (w_issue) begin
                r_update_idx <= w_pick_idx;
                r_target     <= r_shadow[w_pick_idx];
                r_rr_ptr     <= w_pick_idx + IDX_W'(1);
                r_gap        <= GAP_LOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end

            if (w_coal_inc) begin
                r_coal <= r_coal + 16'd1;
            end
        end
    end

    // NOTE: the shadow file has no reset; a channel is only read after a write has set its pending bit.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_shadow[wr_idx] <= wr_target;
        end
    end

    assign update_en    = r_update_en;
    assign update_idx   = r_update_idx;
    assign target_in    = r_target;
    assign pend_mask    = r_pend;
    assign coalesce_cnt = r_coal;
    assign busy         = (r_state == DRAIN) || (!sync_mode && (r_pend != '0));

endmodule
